// File: rtl/multi_cycle_dist_cmp_pkg.sv
// Shared definitions for the multi-cycle point-in-circle comparator:
// FSM state encoding and the distance-squared width helper.
package multi_cycle_dist_cmp_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SQX    = 3'd1,
    ST_ADDSQY = 3'd2,
    ST_CMP    = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  // Two full-scale squares summed need one bit beyond 2*coord_w.
  function automatic int dist_w(input int coord_w);
    return 2 * coord_w + 1;
  endfunction

endpackage

// File: rtl/multi_cycle_dist_cmp_signed_diff_sq.sv
// Combinational (a-b)^2 for unsigned inputs; the difference is formed as a
// signed COORD_W+1 value and squared via its magnitude.
module signed_diff_sq #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0]   a,
  input  logic [COORD_W-1:0]   b,
  output logic [2*COORD_W-1:0] sq
);

  logic signed [COORD_W:0] diff;
  logic        [COORD_W-1:0] mag;

  always_comb begin
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    // |a-b| never exceeds 2^COORD_W-1, so the magnitude fits COORD_W bits.
    mag  = diff[COORD_W] ? COORD_W'(-diff) : COORD_W'(diff);
    sq   = (2*COORD_W)'(mag) * (2*COORD_W)'(mag);
  end

endmodule

// File: rtl/multi_cycle_dist_cmp.sv
// Multi-cycle point-in-circle test: one shared squarer computes (x-cx)^2 +
// (y-cy)^2 over SQX/ADDSQY, compares against r_sq and keeps a saturating hit count.
module multi_cycle_dist_cmp
  import multi_cycle_dist_cmp_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int DIST_W    = dist_w(COORD_W),
  parameter int INCLUSIVE = 0,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid holds with stable data until out_ready.
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [DIST_W-1:0]  r_sq,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               in_circle,
  output logic [DIST_W-1:0]  dist_sq,
  output logic [CNT_W-1:0]   hit_cnt,
  input  logic               cnt_clr,
  output logic [STATE_W-1:0] state_dbg
);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
  logic [DIST_W-1:0]   r_sq_q, r_sq_d;
  logic [DIST_W-1:0]   acc_q, acc_d;
  logic [DIST_W-1:0]   dist_sq_q, dist_sq_d;
  logic                in_circle_q, in_circle_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;

  logic [COORD_W-1:0]   sq_a, sq_b;
  logic [2*COORD_W-1:0] sq;
  logic                 cmp_hit;
  logic                 deliver;

  // The single squarer sees x/cx in SQX and y/cy in ADDSQY.
  always_comb begin
    sq_a = (state_q == ST_ADDSQY) ? y_q  : x_q;
    sq_b = (state_q == ST_ADDSQY) ? cy_q : cx_q;
  end

  signed_diff_sq #(
    .COORD_W (COORD_W)
  ) u_sq (
    .a  (sq_a),
    .b  (sq_b),
    .sq (sq)
  );

  always_comb begin
    cmp_hit = (INCLUSIVE != 0) ? (acc_q <= r_sq_q) : (acc_q < r_sq_q);
    deliver = out_valid_q && out_ready;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    r_sq_d      = r_sq_q;
    acc_d       = acc_q;
    dist_sq_d   = dist_sq_q;
    in_circle_d = in_circle_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          cx_d    = cx;
          cy_d    = cy;
          r_sq_d  = r_sq;
          state_d = ST_SQX;
        end
      end
      ST_SQX: begin
        acc_d   = DIST_W'(sq);
        state_d = ST_ADDSQY;
      end
      ST_ADDSQY: begin
        acc_d   = acc_q + DIST_W'(sq);
        state_d = ST_CMP;
      end
      ST_CMP: begin
        dist_sq_d   = acc_q;
        in_circle_d = cmp_hit;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Clear has priority over a hit delivered on the same edge.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d = '0;
    end else if (deliver && in_circle_q && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      r_sq_q      <= '0;
      acc_q       <= '0;
      dist_sq_q   <= '0;
      in_circle_q <= 1'b0;
      out_valid_q <= 1'b0;
      hit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      r_sq_q      <= r_sq_d;
      acc_q       <= acc_d;
      dist_sq_q   <= dist_sq_d;
      in_circle_q <= in_circle_d;
      out_valid_q <= out_valid_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = out_valid_q;
    in_circle = in_circle_q;
    dist_sq   = dist_sq_q;
    hit_cnt   = hit_cnt_q;
    state_dbg = state_q;
  end

endmodule
